// File: rtl/vga_region_pkg.sv
// Shared types for the multi-region VGA selection path.
// region_t holds one rectangle; coordinates are zero-extended from N bits.
package vga_region_pkg;

  // Widest supported counter width; narrower N uses the low bits.
  localparam int MAX_N = 16;
  // One extra bit so x+w / y+h never wrap.
  localparam int EXT_W = MAX_N + 1;

  typedef struct packed {
    logic [MAX_N-1:0] x;
    logic [MAX_N-1:0] y;
    logic [MAX_N-1:0] w;
    logic [MAX_N-1:0] h;
    logic             enable;
    logic             outline;
  } region_t;

  function automatic logic [EXT_W-1:0] ext(input logic [MAX_N-1:0] a);
    return {1'b0, a};
  endfunction

endpackage

// File: rtl/vga_region_selector_if.sv
// Pixel, region-write and result signals of vga_region_selector.
// master drives pixels and writes; slave is the selector.
interface vga_region_selector_if #(
  parameter int N     = 10,
  parameter int IDX_W = 2
);
  logic [N-1:0]     h_count;
  logic [N-1:0]     v_count;
  logic             pix_valid;
  logic             frame_start;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [N-1:0]     wr_x;
  logic [N-1:0]     wr_y;
  logic [N-1:0]     wr_w;
  logic [N-1:0]     wr_h;
  logic             wr_enable;
  logic             wr_outline;
  logic             out_valid;
  logic             user_area;
  logic [IDX_W-1:0] region_idx;
  logic             on_border;

  modport master (
    output h_count, v_count, pix_valid, frame_start,
    output wr_en, wr_idx, wr_x, wr_y, wr_w, wr_h,
    output wr_enable, wr_outline,
    input  out_valid, user_area, region_idx, on_border
  );

  modport slave (
    input  h_count, v_count, pix_valid, frame_start,
    input  wr_en, wr_idx, wr_x, wr_y, wr_w, wr_h,
    input  wr_enable, wr_outline,
    output out_valid, user_area, region_idx, on_border
  );
endinterface

// File: rtl/vga_region_selector_hit_cell.sv
// region_hit_cell: combinational hit/border test of one pixel vs one region.
// Ports: region (rect), h/v (pixel) -> hit (after outline mask), border.
module region_hit_cell
  import vga_region_pkg::*;
#(
  parameter int N         = 10,
  parameter int BORDER_PX = 1
) (
  input  region_t      region,
  input  logic [N-1:0] h,
  input  logic [N-1:0] v,
  output logic         hit,
  output logic         border
);
  logic [EXT_W-1:0] hx, vy, x0, y0, x1, y1, bp;
  logic             in_box, near;

  always_comb begin
    hx = ext(MAX_N'(h));
    vy = ext(MAX_N'(v));
    x0 = ext(region.x);
    y0 = ext(region.y);
    // End is exclusive; w=0 or h=0 leaves an empty box.
    x1 = x0 + ext(region.w);
    y1 = y0 + ext(region.h);
    bp = EXT_W'(BORDER_PX);
    in_box = region.enable &&
             hx >= x0 && hx < x1 &&
             vy >= y0 && vy < y1;
    // Distances are only meaningful inside the box.
    near = (hx - x0 < bp) ||
           (x1 - 1 - hx < bp) ||
           (vy - y0 < bp) ||
           (y1 - 1 - vy < bp);
    border = in_box && near;
    hit    = in_box && (!region.outline || near);
  end
endmodule

// File: rtl/vga_region_selector.sv
// vga_region_selector: double-buffered multi-rectangle pixel hit test.
// Ports: clk, rst (async high), bus (pixels, writes, 2-cycle results).
module vga_region_selector
  import vga_region_pkg::*;
#(
  parameter int N           = 10,
  parameter int NUM_REGIONS = 4,
  parameter int IDX_W       = (NUM_REGIONS > 1) ?
                              $clog2(NUM_REGIONS) : 1,
  parameter int BORDER_PX   = 1
) (
  input logic                  clk,
  input logic                  rst,
  vga_region_selector_if.slave bus
);
  region_t shadow    [NUM_REGIONS];
  region_t active    [NUM_REGIONS];
  region_t shadow_nx [NUM_REGIONS];
  region_t use_bank  [NUM_REGIONS];
  region_t wr_entry;

  logic [NUM_REGIONS-1:0] c_hit, c_border;
  logic [NUM_REGIONS-1:0] s1_hit, s1_border;
  logic                   s1_valid;

  logic             any_hit, win_border;
  logic [IDX_W-1:0] win_idx;

  // Out-of-range wr_idx matches no entry and is dropped.
  always_comb begin
    wr_entry = '{x: MAX_N'(bus.wr_x), y: MAX_N'(bus.wr_y),
                 w: MAX_N'(bus.wr_w), h: MAX_N'(bus.wr_h),
                 enable: bus.wr_enable, outline: bus.wr_outline};
    for (int r = 0; r < NUM_REGIONS; r++) begin
      shadow_nx[r] = shadow[r];
      if (bus.wr_en && bus.wr_idx == IDX_W'(r))
        shadow_nx[r] = wr_entry;
      // Pixel in the commit cycle already sees the new bank.
      use_bank[r] = bus.frame_start ? shadow_nx[r] : active[r];
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cell
    region_hit_cell #(
      .N         (N),
      .BORDER_PX (BORDER_PX)
    ) u_cell (
      .region (use_bank[g]),
      .h      (bus.h_count),
      .v      (bus.v_count),
      .hit    (c_hit[g]),
      .border (c_border[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        shadow[r] <= '0;
        active[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        shadow[r] <= shadow_nx[r];
        if (bus.frame_start) active[r] <= shadow_nx[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hit    <= '0;
      s1_border <= '0;
      s1_valid  <= 1'b0;
    end else begin
      s1_hit    <= c_hit;
      s1_border <= c_border;
      s1_valid  <= bus.pix_valid;
    end
  end

  // Lowest index wins: scan downward so the last match is the lowest.
  always_comb begin
    any_hit    = 1'b0;
    win_idx    = '0;
    win_border = 1'b0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (s1_hit[r]) begin
        any_hit    = 1'b1;
        win_idx    = IDX_W'(r);
        win_border = s1_border[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.user_area  <= 1'b0;
      bus.region_idx <= '0;
      bus.on_border  <= 1'b0;
    end else begin
      bus.out_valid  <= s1_valid;
      bus.user_area  <= s1_valid && any_hit;
      bus.region_idx <= win_idx;
      bus.on_border  <= s1_valid && any_hit && win_border;
    end
  end
endmodule

// File: tb/tb_vga_region_selector.sv
// Directed bench for vga_region_selector: vector table plus
// hand-written double-buffer, pix_valid and reset sequences.
module tb_vga_region_selector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  vga_region_selector_if #(.N(10), .IDX_W(2)) bus ();

  vga_region_selector #(
    .N           (10),
    .NUM_REGIONS (4),
    .IDX_W       (2),
    .BORDER_PX   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int ua;
    int idx;
    int bd;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int ov, input int ua,
                            input int idx, input int bd);
    chk({tag, ".out_valid"},  int'(bus.out_valid),  ov);
    chk({tag, ".user_area"},  int'(bus.user_area),  ua);
    chk({tag, ".region_idx"}, int'(bus.region_idx), idx);
    chk({tag, ".on_border"},  int'(bus.on_border),  bd);
  endtask

  task automatic idle();
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.wr_en       = 1'b0;
  endtask

  task automatic wr(input int idx, input int x, input int y, input int w,
                    input int h, input bit en, input bit ol);
    bus.wr_en      = 1'b1;
    bus.wr_idx     = 2'(idx);
    bus.wr_x       = 10'(x);
    bus.wr_y       = 10'(y);
    bus.wr_w       = 10'(w);
    bus.wr_h       = 10'(h);
    bus.wr_enable  = en;
    bus.wr_outline = ol;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic commit();
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
  endtask

  // One pixel, then wait out the two-cycle latency.
  task automatic pix(input int h, input int v, input bit pv);
    bus.h_count   = 10'(h);
    bus.v_count   = 10'(v);
    bus.pix_valid = pv;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pix(vt[i].h, vt[i].v, 1'b1);
      expect_out($sformatf("vec%0d(%0d,%0d)", i, vt[i].h, vt[i].v),
                 1, vt[i].ua, vt[i].idx, vt[i].bd);
    end
  endtask

  initial begin
    // Filled region0 {100,50,20,10}
    vt[0]  = '{100,  50, 1, 0, 1};
    vt[1]  = '{110,  55, 1, 0, 0};
    vt[2]  = '{120,  55, 0, 0, 0};
    vt[3]  = '{119,  59, 1, 0, 1};
    vt[4]  = '{ 99,  50, 0, 0, 0};
    // Region0 full screen, region2 small, region1 outline
    vt[5]  = '{205, 205, 1, 0, 0};
    vt[6]  = '{300, 304, 1, 0, 0};
    vt[7]  = '{  0, 240, 1, 0, 1};
    vt[8]  = '{639, 479, 1, 0, 1};
    vt[9]  = '{640,  10, 0, 0, 0};
    // Region0 disabled
    vt[10] = '{205, 205, 1, 2, 0};
    vt[11] = '{200, 200, 1, 2, 1};
    vt[12] = '{300, 304, 1, 1, 1};
    vt[13] = '{303, 303, 0, 0, 0};
    vt[14] = '{307, 307, 1, 1, 1};
    vt[15] = '{308, 304, 0, 0, 0};
    // Region3 {1020,0,10,10} clips at the counter end
    vt[16] = '{1023,  5, 1, 3, 0};
    vt[17] = '{   2,  5, 0, 0, 0};
    vt[18] = '{1020,  0, 1, 3, 1};
    // Region3 with w=0
    vt[19] = '{1020,  5, 0, 0, 0};
    vt[20] = '{1023,  5, 0, 0, 0};

    bus.h_count = '0;
    bus.v_count = '0;
    bus.wr_idx  = '0;
    bus.wr_x = '0; bus.wr_y = '0; bus.wr_w = '0; bus.wr_h = '0;
    bus.wr_enable = 1'b0;
    bus.wr_outline = 1'b0;
    idle();

    #1;
    expect_out("reset", 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    wr(0, 100, 50, 20, 10, 1, 0);
    commit();
    run(0, 4);

    wr(0, 0, 0, 640, 480, 1, 0);
    wr(2, 200, 200, 10, 10, 1, 0);
    wr(1, 300, 300, 8, 8, 1, 1);
    commit();
    run(5, 9);

    wr(0, 0, 0, 640, 480, 0, 0);
    commit();
    run(10, 15);

    wr(3, 1020, 0, 10, 10, 1, 0);
    commit();
    run(16, 18);

    wr(3, 1020, 0, 0, 10, 1, 0);
    commit();
    run(19, 20);

    // Mid-frame write stays in shadow until frame_start.
    wr(0, 10, 10, 5, 5, 1, 0);
    pix(12, 12, 1'b1);
    expect_out("stale", 1, 0, 0, 0);
    commit();
    pix(12, 12, 1'b1);
    expect_out("committed", 1, 1, 0, 0);

    // Write, commit and pixel all in one cycle.
    bus.wr_en = 1'b1; bus.wr_idx = 2'd0;
    bus.wr_x = 10'd20; bus.wr_y = 10'd20;
    bus.wr_w = 10'd5;  bus.wr_h = 10'd5;
    bus.wr_enable = 1'b1; bus.wr_outline = 1'b0;
    bus.frame_start = 1'b1;
    bus.h_count = 10'd22; bus.v_count = 10'd22;
    bus.pix_valid = 1'b1;
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    expect_out("wr_commit", 1, 1, 0, 0);
    pix(12, 12, 1'b1);
    expect_out("old_gone", 1, 0, 0, 0);

    // Invalid pixel inside a region is masked.
    pix(22, 22, 1'b0);
    expect_out("no_valid", 0, 0, 0, 0);

    // Stream, then asynchronous reset mid-frame.
    bus.h_count = 10'd22; bus.v_count = 10'd22;
    bus.pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_out("stream", 1, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    expect_out("post_rst", 1, 0, 0, 0);
    idle();
    wr(0, 20, 20, 5, 5, 1, 0);
    pix(22, 22, 1'b1);
    expect_out("no_commit", 1, 0, 0, 0);
    commit();
    pix(22, 22, 1'b1);
    expect_out("recommit", 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
